// File: rtl/i2c_oled_target.sv
// Write-only I2C target for SSD1306-style OLED controllers.
// Decodes the address byte, then alternates control bytes (Co, D/C#) and
// payload bytes, presenting each payload byte with a one-cycle strobe.
// SCL and SDA are oversampled on clk; all bus decisions use synchronized levels.
module i2c_oled_target #(
  parameter logic [6:0] ADDRESS     = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_pull_low,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_is_cmd,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy
);

  // Two flops is the floor for metastability protection.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_e;

  // Synchronizer chains and previous-sample flops for edge detection.
  logic [STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [STAGES-1:0] sda_sync_q, sda_sync_d;
  logic              scl_prev_q, scl_prev_d;
  logic              sda_prev_q, sda_prev_d;

  // Protocol state and datapath.
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        ack_drive_q, ack_drive_d;
  logic        co_q, co_d;
  logic        dc_q, dc_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_is_cmd_q, byte_is_cmd_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        busy_q, busy_d;

  // Decoded bus events.
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       receiving;
  logic       in_frame;

  assign scl_s = scl_sync_q[STAGES-1];
  assign sda_s = sda_sync_q[STAGES-1];

  // SCL must be high on both samples so that a simultaneous SCL/SDA change
  // is never mistaken for a START or STOP.
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign rx_byte   = {shift_q, sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign receiving = (state_q == ST_ADDR) || (state_q == ST_CTRL) || (state_q == ST_DATA);
  assign in_frame  = (state_q == ST_ADDR_ACK) || (state_q == ST_CTRL) ||
                     (state_q == ST_CTRL_ACK) || (state_q == ST_DATA) ||
                     (state_q == ST_DATA_ACK);

  // Next values for the synchronizer chains and previous-sample flops.
  always_comb begin
    scl_sync_d = {scl_sync_q[STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[STAGES-2:0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Synchronizer registers, preset to the idle-bus level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: presetting to 1 (idle bus) keeps reset release from looking like an SDA/SCL edge.
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  // Next-state and datapath logic; bus conditions override bit activity.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    ack_drive_d   = ack_drive_q;
    co_d          = co_q;
    dc_d          = dc_q;
    byte_out_d    = byte_out_q;
    byte_is_cmd_d = byte_is_cmd_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;

    if (start_det || stop_det) begin
      // Any partial byte is dropped and SDA is let go.
      state_d     = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d   = 3'd0;
      ack_drive_d = 1'b0;
      frame_end_d = in_frame;
    end else begin
      if (receiving && scl_rise) begin
        shift_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            if ((rx_byte[7:1] == ADDRESS) && !rx_byte[0]) begin
              state_d       = ST_ADDR_ACK;
              frame_start_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_CTRL: begin
          if (byte_done) begin
            co_d    = rx_byte[7];
            dc_d    = rx_byte[6];
            state_d = ST_CTRL_ACK;
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            byte_out_d    = rx_byte;
            byte_is_cmd_d = ~dc_q;
            byte_valid_d  = 1'b1;
            state_d       = ST_DATA_ACK;
          end
        end
        ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
          // First falling edge grabs SDA, the second one lets it go.
          if (scl_fall) begin
            if (!ack_drive_q) begin
              ack_drive_d = 1'b1;
            end else begin
              ack_drive_d = 1'b0;
              case (state_q)
                ST_ADDR_ACK: state_d = ST_CTRL;
                ST_CTRL_ACK: state_d = ST_DATA;
                default:     state_d = co_q ? ST_CTRL : ST_DATA;
              endcase
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_ADDR_ACK) || (state_d == ST_CTRL) ||
             (state_d == ST_CTRL_ACK) || (state_d == ST_DATA) ||
             (state_d == ST_DATA_ACK);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      ack_drive_q   <= 1'b0;
      co_q          <= 1'b0;
      dc_q          <= 1'b0;
      byte_out_q    <= 8'h00;
      byte_is_cmd_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      ack_drive_q   <= ack_drive_d;
      co_q          <= co_d;
      dc_q          <= dc_d;
      byte_out_q    <= byte_out_d;
      byte_is_cmd_q <= byte_is_cmd_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
    end
  end

  // SDA is released in the very cycle a START or STOP is seen.
  assign sda_pull_low = ack_drive_q & ~(start_det | stop_det);
  assign byte_out     = byte_out_q;
  assign byte_is_cmd  = byte_is_cmd_q;
  assign byte_valid   = byte_valid_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign busy         = busy_q;

endmodule
